// File: rtl/tristate_bus_pkg.sv
// rtl/tristate_bus_pkg.sv - shared state encoding and round-robin pick helper for the tristate bus arbiter
package tristate_bus_pkg;

    localparam int MAX_NCH = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Width of an index over n items, never below one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set request at or above ptr, wrapping modulo nch.
    function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 nch);
        rr_pick_t         p;
        int               c;
        logic [IDX_W-1:0] cidx;
        p.valid = 1'b0;
        p.idx   = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            c    = (int'(ptr) + i) % nch;
            cidx = IDX_W'(c);
            if (i < nch && !p.valid && req[cidx]) begin
                p.valid = 1'b1;
                p.idx   = cidx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr.sv
// rtl/tristate_bus_arbiter_rr.sv - round-robin pick with registered pointer advanced on each release
module rr_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = safe_clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_i,
    input  logic           release_i,
    input  logic [PW-1:0]  owner_i,
    output logic           pick_valid_o,
    output logic [PW-1:0]  pick_idx_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    rr_pick_t      pick;

    // The pick sees the post-release pointer so a zero-turnaround handover skips the old owner.
    always_comb begin
        ptr_d = ptr_q;
        if (release_i) begin
            ptr_d = (owner_i == PW'(NCH - 1)) ? '0 : owner_i + 1'b1;
        end
    end

    assign pick         = rr_pick(MAX_NCH'(req_i), IDX_W'(ptr_d), NCH);
    assign pick_valid_o = pick.valid;
    assign pick_idx_o   = PW'(pick.idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner of a shared tristate bus with burst limit and turnaround gap
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int INVERT     = 1,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*WIDTH-1:0]    data_in,
    output wire  [WIDTH-1:0]        bus,
    output logic [NCH-1:0]          grant,
    output logic [$clog2(NCH)-1:0]  owner,
    output logic                    busy
);

    localparam int                PW         = safe_clog2(NCH);
    localparam int                BW         = safe_clog2(MAX_BURST);
    localparam logic [BW-1:0]     BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [2:0]        TA_INIT    = 3'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [WIDTH-1:0]  INV_MASK   = (INVERT != 0) ? '1 : '0;

    bus_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [2:0]       ta_q, ta_d;
    logic             drive_en_q;
    logic             rel;
    logic             arb;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;

    rr_arbiter #(
        .NCH (NCH),
        .PW  (PW)
    ) u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .release_i    (rel),
        .owner_i      (owner_q),
        .pick_valid_o (pick_valid),
        .pick_idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        owner_d = owner_q;
        burst_d = burst_q;
        ta_d    = ta_q;
        rel     = 1'b0;
        arb     = 1'b0;
        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_DRIVE: begin
                if (req[owner_q] && (burst_q < BURST_LAST)) begin
                    data_d  = data_in[owner_q*WIDTH +: WIDTH] ^ INV_MASK;
                    burst_d = burst_q + 1'b1;
                end else begin
                    rel     = 1'b1;
                    grant_d = '0;
                    burst_d = '0;
                    if (TURNAROUND > 0) begin
                        state_d = ST_TURN;
                        ta_d    = TA_INIT;
                    end else begin
                        arb = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (ta_q == 3'd0) begin
                    arb = 1'b1;
                end else begin
                    ta_d = ta_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (arb) begin
            if (pick_valid) begin
                state_d = ST_DRIVE;
                grant_d = NCH'(1) << pick_idx;
                owner_d = pick_idx;
                burst_d = '0;
                data_d  = data_in[pick_idx*WIDTH +: WIDTH] ^ INV_MASK;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            grant_q    <= '0;
            owner_q    <= '0;
            burst_q    <= '0;
            ta_q       <= '0;
            drive_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            ta_q       <= ta_d;
            drive_en_q <= (state_d == ST_DRIVE);
        end
    end

    // Enable comes straight from a flop so the bus cannot glitch across an ownership change.
    assign bus   = drive_en_q ? data_q : 'z;
    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - randomized reference-model bench over four parameter variants
module tb_tristate_bus_arbiter;

    localparam int INV_P [4] = '{1, 1, 0, 1};
    localparam int TA_P  [4] = '{1, 1, 0, 2};
    localparam int MB_P  [4] = '{3, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;

    wire  [7:0]  bus0, bus1, bus2, bus3;
    logic        bus_z   [4];
    logic [7:0]  bus_v   [4];
    logic [3:0]  grant_v [4];
    logic [1:0]  owner_v [4];
    logic        busy_v  [4];

    int m_own [4];
    int m_last[4];
    int m_used[4];
    int m_gap [4];
    int m_ptr [4];
    logic [7:0] m_dat[4];

    logic       e_z    [4];
    logic [7:0] e_bus  [4];
    logic [3:0] e_grant[4];
    logic [1:0] e_owner[4];
    logic       e_busy [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.WIDTH(8), .NCH(4), .INVERT(1), .TURNAROUND(1), .MAX_BURST(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .bus(bus0), .grant(grant_v[0]), .owner(owner_v[0]), .busy(busy_v[0]));
    tristate_bus_arbiter #(.WIDTH(8), .NCH(4), .INVERT(1), .TURNAROUND(1), .MAX_BURST(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .bus(bus1), .grant(grant_v[1]), .owner(owner_v[1]), .busy(busy_v[1]));
    tristate_bus_arbiter #(.WIDTH(8), .NCH(4), .INVERT(0), .TURNAROUND(0), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .bus(bus2), .grant(grant_v[2]), .owner(owner_v[2]), .busy(busy_v[2]));
    tristate_bus_arbiter #(.WIDTH(8), .NCH(4), .INVERT(1), .TURNAROUND(2), .MAX_BURST(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .bus(bus3), .grant(grant_v[3]), .owner(owner_v[3]), .busy(busy_v[3]));

    assign bus_z[0] = (bus0 === 8'hzz);
    assign bus_z[1] = (bus1 === 8'hzz);
    assign bus_z[2] = (bus2 === 8'hzz);
    assign bus_z[3] = (bus3 === 8'hzz);
    assign bus_v[0] = bus0;
    assign bus_v[1] = bus1;
    assign bus_v[2] = bus2;
    assign bus_v[3] = bus3;

    function automatic logic req_bit(input int ch);
        return req[2'(ch)];
    endfunction

    function automatic logic [7:0] chan_data(input int ch);
        return 8'(data_in >> (8 * ch));
    endfunction

    // Reference: owner (-1 = none), drive cycles used, remaining gap cycles, next search start.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            bit arb;
            arb = 1'b0;
            if (!rst_n) begin
                m_own[k] = -1; m_last[k] = 0; m_ptr[k] = 0; m_gap[k] = 0; m_used[k] = 0;
            end else begin
                if (m_own[k] >= 0) begin
                    if (req_bit(m_own[k]) && m_used[k] < MB_P[k]) begin
                        m_dat[k] = chan_data(m_own[k]) ^ ((INV_P[k] != 0) ? 8'hFF : 8'h00);
                        m_used[k]++;
                    end else begin
                        m_ptr[k] = (m_own[k] + 1) % 4;
                        m_own[k] = -1;
                        if (TA_P[k] > 0) m_gap[k] = TA_P[k];
                        else arb = 1'b1;
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                    if (m_gap[k] == 0) arb = 1'b1;
                end else begin
                    arb = 1'b1;
                end
                if (arb) begin
                    for (int i = 0; i < 4 && m_own[k] < 0; i++) begin
                        int w;
                        w = (m_ptr[k] + i) % 4;
                        if (req_bit(w)) begin
                            m_own[k] = w; m_last[k] = w; m_used[k] = 1;
                            m_dat[k] = chan_data(w) ^ ((INV_P[k] != 0) ? 8'hFF : 8'h00);
                        end
                    end
                end
            end
            e_z[k]     = (m_own[k] < 0);
            e_bus[k]   = m_dat[k];
            e_grant[k] = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0000;
            e_owner[k] = 2'(m_last[k]);
            e_busy[k]  = (m_own[k] >= 0) || (m_gap[k] > 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        req = '0;
        rst_n = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) rst_n = 1'b1;
            data_in = $urandom;
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL reset dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
        checks++;
        if (bus_z[0] !== 1'b1 || grant_v[0] !== 4'b0000 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got z=%b g=%b busy=%b want z=1 g=0000 busy=0", bus_z[0], grant_v[0], busy_v[0]);
        end
    endtask

    task automatic test_single_invert();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req = (c < 3) ? 4'b0010 : 4'b0000;
            data_in = $urandom;
            data_in[15:8] = 8'hA5;
            tick();
            if (c == 0) begin
                checks++;
                if (grant_v[0] !== 4'b0010 || owner_v[0] !== 2'd1 || bus_v[0] !== 8'h5A || bus_v[2] !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_first: got g=%b o=%0d bus0=%h bus2=%h want g=0010 o=1 bus0=5a bus2=a5",
                             grant_v[0], owner_v[0], bus_v[0], bus_v[2]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL single dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
    endtask

    task automatic test_burst_limit();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            data_in = $urandom;
            data_in[23:16] = (c < 4) ? 8'(c + 1) : 8'($urandom);
            tick();
            if (c == 2 || c == 3) begin
                checks++;
                if ((c == 2 && bus_v[0] !== 8'hFC) || (c == 3 && bus_z[0] !== 1'b1)) begin
                    errors++;
                    $display("FAIL burst_edge c%0d: got z=%b bus=%h want %s", c, bus_z[0], bus_v[0], (c == 2) ? "fc" : "z");
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL burst dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            logic [3:0] want_g;
            data_in = $urandom;
            tick();
            // Two drive cycles then one gap, cycling owners 0,1,2,3,0.
            want_g = (c % 3 == 2) ? 4'b0000 : 4'(1 << ((c / 3) % 4));
            checks++;
            if (grant_v[1] !== want_g) begin
                errors++;
                $display("FAIL rr_order c%0d: got g=%b want g=%b", c, grant_v[1], want_g);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL rr dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
    endtask

    task automatic test_zero_turnaround();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        req = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            data_in = $urandom;
            tick();
            checks++;
            if (bus_z[2] !== 1'b0 || $countones(grant_v[2]) != 1 || bus_v[2] !== chan_data(int'(owner_v[2]))) begin
                if (c > 0 || bus_z[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_ta c%0d: got z=%b g=%b bus=%h want driven one-hot straight data", c, bus_z[2], grant_v[2], bus_v[2]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL zero_ta dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
            data_in = $urandom;
        end
    endtask

    task automatic test_reset_mid_drive();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        req = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            rst_n = (c == 2) ? 1'b0 : 1'b1;
            data_in = $urandom;
            tick();
            if (c == 2 || c == 3) begin
                checks++;
                if ((c == 2 && (bus_z[0] !== 1'b1 || grant_v[0] !== 4'b0000))
                    || (c == 3 && (grant_v[0] !== 4'b1000 || owner_v[0] !== 2'd3))) begin
                    errors++;
                    $display("FAIL mid_reset c%0d: got z=%b g=%b o=%0d", c, bus_z[0], grant_v[0], owner_v[0]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL mid_reset dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            data_in = $urandom;
            tick();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus_z[k] !== e_z[k] || (!e_z[k] && bus_v[k] !== e_bus[k]) || grant_v[k] !== e_grant[k]
                    || owner_v[k] !== e_owner[k] || busy_v[k] !== e_busy[k]) begin
                    errors++;
                    $display("FAIL random dut%0d c%0d: got z=%b bus=%h g=%b o=%0d busy=%b want z=%b bus=%h g=%b o=%0d busy=%b",
                             k, c, bus_z[k], bus_v[k], grant_v[k], owner_v[k], busy_v[k], e_z[k], e_bus[k], e_grant[k], e_owner[k], e_busy[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_own[k] = -1; m_last[k] = 0; m_used[k] = 0; m_gap[k] = 0; m_ptr[k] = 0; m_dat[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_single_invert();
        test_burst_limit();
        test_round_robin();
        test_zero_turnaround();
        test_reset_mid_drive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
